// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus valid/ready output stream of the burst reader.
// The master modport is the reader side; the slave modport is the FIFO and stream sink side.
interface fifo_burst_reader_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic              fifo_r_en;
    logic [DATA_W-1:0] fifo_rdata;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        input  fifo_empty, fifo_rdata, m_ready,
        output fifo_r_en, m_data, m_valid, m_last
    );

    modport slave (
        output fifo_empty, fifo_rdata, m_ready,
        input  fifo_r_en, m_data, m_valid, m_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops burst_len words from the synchronous FIFO and forwards them on a valid/ready stream.
// A 2-entry output buffer hides the FIFO's one-cycle read latency.
module fifo_burst_reader #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LEN_W-1:0]           burst_len,
    output logic                       busy,
    output logic                       done,
    output logic [LEN_W-1:0]           words_read,
    fifo_burst_reader_if.master        bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  sent;
    logic              inflight;
    logic [1:0]        buf_count;
    logic [DATA_W-1:0] buf_head;
    logic [DATA_W-1:0] buf_tail;
    logic              pop;
    logic [1:0]        occ_after;

    assign pop       = bus.m_valid && bus.m_ready;
    // Buffer slots plus the word in flight, after this cycle's pop, must leave room.
    assign occ_after = buf_count + {1'b0, inflight} - {1'b0, pop};

    assign bus.fifo_r_en = (state == S_RUN) && (remaining != '0) && !bus.fifo_empty
                           && (occ_after < 2'd2);
    assign bus.m_valid   = (buf_count != 2'd0);
    assign bus.m_data    = buf_head;
    assign bus.m_last    = bus.m_valid && (sent == (len - LEN_W'(1)));

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            len        <= '0;
            remaining  <= '0;
            sent       <= '0;
            words_read <= '0;
            inflight   <= 1'b0;
            buf_count  <= '0;
            buf_head   <= '0;
            buf_tail   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            len        <= burst_len;
                            remaining  <= burst_len;
                            sent       <= '0;
                            words_read <= '0;
                            state      <= S_RUN;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (pop && bus.m_last)
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (bus.fifo_r_en) begin
                remaining  <= remaining - LEN_W'(1);
                words_read <= words_read + LEN_W'(1);
            end
            inflight <= bus.fifo_r_en;

            if (pop)
                sent <= sent + LEN_W'(1);

            // Capture lands at the tail, pop shifts the tail into the head.
            case ({inflight, pop})
                2'b10: begin
                    if (buf_count == 2'd0)
                        buf_head <= bus.fifo_rdata;
                    else
                        buf_tail <= bus.fifo_rdata;
                    buf_count <= buf_count + 2'd1;
                end
                2'b01: begin
                    buf_head  <= buf_tail;
                    buf_count <= buf_count - 2'd1;
                end
                2'b11: begin
                    if (buf_count == 2'd1) begin
                        buf_head <= bus.fifo_rdata;
                    end else begin
                        buf_head <= buf_tail;
                        buf_tail <= bus.fifo_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO, word-order scoreboard checked every cycle,
// and directed bursts with literal expectations.
module tb_fifo_burst_reader;
    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] burst_len;
    logic       busy;
    logic       done;
    logic [7:0] words_read;
    logic       push_en;
    logic [7:0] push_data;

    fifo_burst_reader_if #(.DATA_W(8)) bus ();

    fifo_burst_reader #(.DATA_W(8), .LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
        .words_read (words_read),
        .bus        (bus)
    );

    int checks;
    int failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural FIFO with registered read data.
    logic [7:0] fifo_q[$];
    always @(posedge clk) begin
        if (bus.fifo_r_en && fifo_q.size() != 0)
            bus.fifo_rdata <= fifo_q.pop_front();
        if (push_en)
            fifo_q.push_back(push_data);
        bus.fifo_empty <= (fifo_q.size() == 0);
    end

    // Scoreboard model: words leave the stream in push order, len per accepted burst.
    logic [7:0] exp_q[$];
    logic [8:0] hs_log[$];
    bit         mdl_active, mdl_done, done_next;
    int         mdl_rem, mdl_reads_left, mdl_wr, burst_reads, burst_hs;
    int         hs_total, ren_total, ren_rises, done_total, mvalid_total, busy_total, max_out;
    bit         prev_stall, prev_ren;
    logic [7:0] prev_data;

    always @(negedge clk) begin
        if (push_en)
            exp_q.push_back(push_data);
        if (rst) begin
            // A pop issued in the reset cycle still leaves the FIFO; undelivered words are lost.
            if (bus.fifo_r_en === 1'b1) burst_reads++;
            for (int i = 0; i < burst_reads - burst_hs; i++)
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            mdl_active = 0; mdl_done = 0; mdl_rem = 0; mdl_reads_left = 0;
            mdl_wr = 0; burst_reads = 0; burst_hs = 0;
            prev_stall = 0; prev_ren = 0;
        end else begin
            chk("busy", busy, mdl_active);
            chk("done", done, mdl_done);
            chk("words_read", words_read, mdl_wr);
            chk("ren_while_empty", bus.fifo_r_en && bus.fifo_empty, 0);
            if (!mdl_active) chk("idle_no_valid", bus.m_valid, 0);
            if (bus.m_valid) chk("m_last", bus.m_last, mdl_rem == 1);
            else             chk("m_last_no_valid", bus.m_last, 0);
            if (prev_stall) begin
                chk("stall_valid", bus.m_valid, 1);
                chk("stall_data", bus.m_data, prev_data);
            end
            done_next = 0;
            if (done) done_total++;
            if (busy) busy_total++;
            if (bus.m_valid) mvalid_total++;
            if (bus.fifo_r_en) begin
                chk("ren_budget", mdl_reads_left > 0, 1);
                mdl_reads_left--; burst_reads++; ren_total++; mdl_wr++;
                if (!prev_ren) ren_rises++;
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) chk("stream_extra", 1, 0);
                else chk("stream_data", bus.m_data, exp_q.pop_front());
                hs_log.push_back({bus.m_last, bus.m_data});
                hs_total++; burst_hs++; mdl_rem--;
                if (mdl_rem == 0) begin
                    mdl_active = 0;
                    done_next  = 1;
                end
            end
            chk("outstanding", (burst_reads - burst_hs) <= 2, 1);
            if (burst_reads - burst_hs > max_out) max_out = burst_reads - burst_hs;
            if (start && !mdl_active && !mdl_done) begin
                if (burst_len != 0) begin
                    mdl_active = 1; mdl_rem = burst_len; mdl_reads_left = burst_len;
                    mdl_wr = 0; burst_reads = 0; burst_hs = 0;
                end else begin
                    done_next = 1;
                end
            end
            mdl_done   = done_next;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_ren   = bus.fifo_r_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        push_en = 1'b1;
        push_data = w;
        tick();
        push_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] n);
        start = 1'b1;
        burst_len = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((mdl_active || mdl_done) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk({name, "_timeout"}, 0, 1);
        tick();
    endtask

    task automatic chk_hs(input string name, input int idx, input logic [7:0] d, input bit last);
        if (idx >= hs_log.size()) chk({name, "_missing"}, 0, 1);
        else chk(name, hs_log[idx], {last, d});
    endtask

    int hb, rb, rr, db, vb, bb, n;

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; burst_len = '0; push_en = 1'b0; push_data = '0;
        bus.m_ready = 1'b1;
        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_valid", bus.m_valid, 0);
        chk("reset_ren", bus.fifo_r_en, 0);
        rst = 1'b0;
        tick();

        // Basic burst
        push(8'hAA); push(8'hBB); tick();
        hb = hs_total; rb = ren_total; rr = ren_rises; db = done_total;
        pulse_start(8'd2);
        wait_idle("basic");
        chk("basic_count", hs_total - hb, 2);
        chk_hs("basic_w0", hb, 8'hAA, 1'b0);
        chk_hs("basic_w1", hb + 1, 8'hBB, 1'b1);
        chk("basic_reads", ren_total - rb, 2);
        chk("basic_ren_run", ren_rises - rr, 1);
        chk("basic_done", done_total - db, 1);
        chk("basic_words_read", words_read, 2);
        chk("basic_fifo_empty", bus.fifo_empty, 1);

        // Backpressure
        for (int i = 1; i <= 5; i++) push(8'(i));
        tick();
        hb = hs_total; rb = ren_total; max_out = 0;
        bus.m_ready = 1'b0;
        pulse_start(8'd5);
        n = 0;
        while (!bus.m_valid && n < 20) begin tick(); n++; end
        chk("bp_first_valid", bus.m_valid, 1);
        repeat (4) tick();
        chk("bp_stall_data", bus.m_data, 8'h01);
        chk("bp_stall_out", max_out, 2);
        bus.m_ready = 1'b1;
        wait_idle("bp");
        chk("bp_count", hs_total - hb, 5);
        for (int i = 0; i < 5; i++) chk_hs("bp_word", hb + i, 8'(i + 1), i == 4);
        chk("bp_reads", ren_total - rb, 5);

        // Empty stall
        push(8'h10); tick();
        hb = hs_total;
        pulse_start(8'd3);
        repeat (10) tick();
        chk("stall_busy", busy, 1);
        push(8'h11); push(8'h12);
        wait_idle("stall");
        chk_hs("stall_w0", hb, 8'h10, 1'b0);
        chk_hs("stall_w1", hb + 1, 8'h11, 1'b0);
        chk_hs("stall_w2", hb + 2, 8'h12, 1'b1);

        // Zero length
        rb = ren_total; db = done_total; vb = mvalid_total; bb = busy_total;
        pulse_start(8'd0);
        chk("zero_done_pulse", done, 1);
        repeat (4) tick();
        chk("zero_done", done_total - db, 1);
        chk("zero_reads", ren_total - rb, 0);
        chk("zero_valid", mvalid_total - vb, 0);
        chk("zero_busy", busy_total - bb, 0);

        // Start while busy
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
        tick();
        rb = ren_total; hb = hs_total;
        pulse_start(8'd3);
        tick();
        pulse_start(8'd7);
        wait_idle("sb");
        chk("sb_reads", ren_total - rb, 3);
        chk("sb_count", hs_total - hb, 3);
        chk("sb_words_read", words_read, 3);
        hb = hs_total;
        pulse_start(8'd2);
        wait_idle("drain");
        chk_hs("drain_w0", hb, 8'h33, 1'b0);
        chk_hs("drain_w1", hb + 1, 8'h34, 1'b1);

        // Mid-burst reset
        for (int i = 0; i < 6; i++) push(8'(8'h40 + i));
        tick();
        hb = hs_total; db = done_total;
        pulse_start(8'd4);
        n = 0;
        while (hs_total < hb + 2 && n < 40) begin tick(); n++; end
        chk("rst_reached", hs_total - hb, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ren", bus.fifo_r_en, 0);
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_last", bus.m_last, 0);
        chk("rst_data", bus.m_data, 0);
        chk("rst_words_read", words_read, 0);
        repeat (3) tick();
        chk("rst_no_done", done_total - db, 0);
        hb = hs_total;
        pulse_start(8'd2);
        wait_idle("rst_again");
        chk_hs("rst_w0", hb, 8'h44, 1'b0);
        chk_hs("rst_w1", hb + 1, 8'h45, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side consumer for the team's synchronous FIFO (`fifo`).
- On a `start` command it pops exactly `burst_len` words from the FIFO read port (`r_en`/`data_out`/`empty`), honouring `empty`.
- Forwards the words on a valid/ready output stream, tags the final word with `m_last`, and pulses `done`.
- Hides the FIFO's one-cycle read latency behind a 2-entry output buffer, so it sustains one word per cycle.

Parameters:
- DATA_W, 8, width of FIFO data and output stream data.
- LEN_W, 8, width of `burst_len` and internal word counters. Maximum burst is 2^LEN_W-1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle command strobe; sampled only in IDLE.
- burst_len  input  LEN_W  number of words to read; sampled with `start`.
- busy  output  1  high while a burst is in progress (RUN state).
- done  output  1  one-cycle pulse at burst completion.
- fifo_empty  input  1  FIFO `empty` flag.
- fifo_r_en  output  1  FIFO read enable (connects to FIFO `r_en`).
- fifo_rdata  input  DATA_W  FIFO `data_out`; valid from the posedge after the `r_en` posedge.
- m_data  output  DATA_W  output stream data.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream ready.
- m_last  output  1  qualifies `m_data` as the final word of the burst.
- words_read  output  LEN_W  count of words popped from the FIFO in the current or last burst.

Behaviour:
- Reset (`rst`=1 at posedge):
  - State goes to IDLE.
  - Outputs forced low: `busy`, `done`, `fifo_r_en`, `m_valid`, `m_last`.
  - Cleared to 0: `m_data`, `words_read`, buffer count, in-flight flag, remaining count, sent count.
- Reset mid-burst: the burst is abandoned and no `done` pulse is issued. Words already popped from the FIFO are discarded; this is acceptable.

FSM (IDLE, RUN, DONE):
- IDLE, `start` && `burst_len`!=0:
  - Latch `len`; set `remaining` = `burst_len`, `sent` = 0, `words_read` = 0.
  - Go to RUN.
- IDLE, `start` && `burst_len`==0: go to DONE with no FIFO reads.
- RUN: go to DONE on the posedge where the word with `m_last`=1 handshakes (`m_valid`&&`m_ready`).
- DONE: `done`=1 for exactly this one cycle, then IDLE.
- `start` is ignored in RUN and DONE.
- `busy` = (state==RUN).

FIFO read side:
- `pop` = `m_valid` && `m_ready`.
- `fifo_r_en` (combinational) = RUN && `remaining`!=0 && !`fifo_empty` && (`buf_count` + `inflight` − `pop`) < 2.
- `fifo_r_en` is never asserted while `fifo_empty`=1, and never more than `len` times per burst.
- On each posedge with `fifo_r_en`=1: `remaining`−1, `words_read`+1, `inflight` set to 1; otherwise `inflight` is cleared.
- Posedge with `inflight`=1: `fifo_rdata` is captured into the output buffer tail.

Output buffer (2 entries, FIFO order):
- `m_valid` = (`buf_count`!=0); `m_data` = buffer head.
- Simultaneous capture and pop are allowed; `buf_count` is unchanged.
- Capture is guaranteed never to overflow by the credit rule above.
- `m_data`/`m_valid` hold stable while `m_valid`&&!`m_ready`.
- `m_last` = `m_valid` && (`sent` == `len`−1); `sent` increments on each pop.

Throughput and latency:
- With `m_ready` held 1 and the FIFO non-empty, `fifo_r_en` is high for `len` consecutive cycles.
- The first `m_valid` appears 2 cycles after the `start` posedge.
- `done` is asserted the cycle after the last handshake.
- Counters wrap modulo 2^LEN_W; `len` is limited to ≤ 2^LEN_W−1, so no wrap occurs within a legal burst.

Test Plan:
- Basic burst:
  - Stimulus: FIFO preloaded with 0xAA, 0xBB; `start` with `burst_len`=2; `m_ready`=1.
  - Required: `fifo_r_en` high 2 consecutive cycles; stream 0xAA then 0xBB; `m_last` only on 0xBB; `done` one cycle after; `words_read`=2; FIFO `empty`=1 afterwards.
- Backpressure:
  - Stimulus: FIFO holds 0x01..0x05; `burst_len`=5; `m_ready` low for 4 cycles after the first `m_valid`.
  - Required: at most 2 reads outstanding while stalled (`fifo_r_en` stops); `m_data` holds 0x01 stable; resuming yields 0x01..0x05 in order with none lost or duplicated.
- Empty stall:
  - Stimulus: FIFO holds 0x10; `burst_len`=3; push 0x11 and 0x12 ten cycles later.
  - Required: `fifo_r_en` never high while `fifo_empty`=1; `busy` stays 1; output is 0x10, 0x11, 0x12 with `m_last` on 0x12.
- Zero length:
  - Stimulus: `start` with `burst_len`=0.
  - Required: `done` pulses one cycle later; no `fifo_r_en`, no `m_valid`; `busy` never 1.
- Start while busy:
  - Stimulus: second `start` with `burst_len`=7 during a 3-word burst.
  - Required: ignored; exactly 3 words read; `words_read`=3.
- Mid-burst reset:
  - Stimulus: assert `rst` for one cycle after the 2nd handshake of a 4-word burst.
  - Required: all outputs 0 the next cycle; no `done`; a new `start` with `burst_len`=2 then reads the next 2 FIFO words correctly.
